morse_serial_tx: RTL and testbench

- Parametrised successor to the digit-to-Morse encoder.
- Accepts decimal digits through a valid/ready handshake and buffers them in a small FIFO.
- Encodes each digit to its 5-symbol Morse pattern and serialises it as a timed key signal (mark/space) for the LED/buzzer driver.
- Adds unit timing, configurable dash/gap lengths, input buffering, invalid-code flagging and flush.

---
 rtl/morse_pkg.sv | 39 +++
 rtl/morse_serial_tx_if.sv | 9 +
 rtl/morse_fifo.sv | 60 ++++++
 rtl/morse_serial_tx.sv | 159 +++++++++++++++
 tb/tb_morse_serial_tx.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// Shared types and the digit-to-Morse encoding used by the serial Morse transmitter.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_CGAP  = 2'd3
    } state_e;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int DIGIT_W   = 4;
    localparam int PATTERN_W = 5;
    localparam int SYM_COUNT = 5;

    // Bit d set when BCD code d is a legal digit.
    localparam logic [15:0] VALID_DIGITS = 16'h03FF;

    function automatic logic is_valid_digit(input logic [DIGIT_W-1:0] d);
        return VALID_DIGITS[d];
    endfunction

    // Pattern bit 4 is sent first; 1 = dash, 0 = dot. Invalid codes map to all dots.
    function automatic logic [PATTERN_W-1:0] digit_to_morse(input logic [DIGIT_W-1:0] d);
        logic [PATTERN_W-1:0] p;
        p = '0;
        if (d == 4'd0) begin
            p = 5'b11111;
        end else if (d <= 4'd5) begin
            p = 5'b11111 >> d;
        end else if (d <= 4'd9) begin
            p = ~(5'b11111 >> (d - 4'd5));
        end
        return p;
    endfunction

endpackage

// File: rtl/morse_serial_tx_if.sv
// Digit input handshake: the producer offers in_digit with in_valid, the transmitter answers in_ready.
interface morse_serial_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_digit;

    modport master (output in_valid, output in_digit, input  in_ready);
    modport slave  (input  in_valid, input  in_digit, output in_ready);
endinterface

// File: rtl/morse_fifo.sv
// Small synchronous FIFO with clear; count is registered so status flags are glitch-free.
module morse_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/morse_serial_tx.sv
// Buffered decimal-digit Morse transmitter: FIFO-fed FSM that times marks, spaces and character gaps on key_out.
module morse_serial_tx
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES    = 4,
    parameter int DASH_UNITS     = 3,
    parameter int CHAR_GAP_UNITS = 3,
    parameter int DEPTH          = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    morse_serial_tx_if.slave       in_if,
    input  logic                   flush,
    output logic                   key_out,
    output logic                   busy,
    output logic                   err_invalid,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int DOT_CYC  = UNIT_CYCLES;
    localparam int DASH_CYC = DASH_UNITS * UNIT_CYCLES;
    localparam int GAP_CYC  = CHAR_GAP_UNITS * UNIT_CYCLES;
    localparam int TMAX_A   = (DASH_CYC > GAP_CYC) ? DASH_CYC : GAP_CYC;
    localparam int TMAX     = (TMAX_A > DOT_CYC) ? TMAX_A : DOT_CYC;
    localparam int TW       = (TMAX > 1) ? $clog2(TMAX) : 1;

    // Timer holds duration-1 so a state leaves on the edge where it reads zero.
    localparam logic [TW-1:0] T_DOT  = TW'(DOT_CYC - 1);
    localparam logic [TW-1:0] T_DASH = TW'(DASH_CYC - 1);
    localparam logic [TW-1:0] T_GAP  = TW'(GAP_CYC - 1);
    localparam logic [2:0]    LAST_IDX = 3'(SYM_COUNT - 1);

    function automatic logic [TW-1:0] mark_time(input logic sym);
        return (sym == SYM_DASH) ? T_DASH : T_DOT;
    endfunction

    state_e               r_state, w_state_next;
    logic [TW-1:0]        r_timer, w_timer_next;
    logic [3:0]           r_shift, w_shift_next;
    logic [2:0]           r_idx, w_idx_next;
    logic                 r_key, w_key_next;
    logic                 r_busy, w_busy_next;
    logic                 r_err, w_err_next;

    logic                 w_full;
    logic                 w_empty;
    logic [DIGIT_W-1:0]   w_fifo_data;
    logic [PATTERN_W-1:0] w_pattern;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;

    assign in_if.in_ready = !w_full;
    assign w_accept       = in_if.in_valid && in_if.in_ready && !flush;
    assign w_push         = w_accept && is_valid_digit(in_if.in_digit);
    assign w_err_next     = w_accept && !is_valid_digit(in_if.in_digit);
    assign w_pattern      = digit_to_morse(w_fifo_data);

    morse_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DIGIT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (in_if.in_digit),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_shift <= '0;
            r_idx   <= '0;
            r_key   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_shift <= w_shift_next;
            r_idx   <= w_idx_next;
            r_key   <= w_key_next;
            r_busy  <= w_busy_next;
            r_err   <= w_err_next;
        end
    end

    // Shift register keeps only the symbols still to send after the current mark.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_shift_next = r_shift;
        w_idx_next   = r_idx;
        w_pop        = 1'b0;
        if (flush) begin
            w_state_next = ST_IDLE;
            w_timer_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_pattern[3:0];
                        w_idx_next   = '0;
                        w_timer_next = mark_time(w_pattern[4]);
                        w_state_next = ST_MARK;
                    end
                end
                ST_MARK: begin
                    if (r_timer == '0) begin
                        if (r_idx < LAST_IDX) begin
                            w_timer_next = T_DOT;
                            w_state_next = ST_SPACE;
                        end else begin
                            w_timer_next = T_GAP;
                            w_state_next = ST_CGAP;
                        end
                    end else begin
                        w_timer_next = r_timer - 1'b1;
                    end
                end
                ST_SPACE: begin
                    if (r_timer == '0) begin
                        w_idx_next   = r_idx + 3'd1;
                        w_shift_next = {r_shift[2:0], 1'b0};
                        w_timer_next = mark_time(r_shift[3]);
                        w_state_next = ST_MARK;
                    end else begin
                        w_timer_next = r_timer - 1'b1;
                    end
                end
                ST_CGAP: begin
                    if (r_timer == '0) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_timer_next = r_timer - 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_key_next  = (w_state_next == ST_MARK);
        w_busy_next = (w_state_next != ST_IDLE);
    end

    assign key_out     = r_key;
    assign busy        = r_busy;
    assign err_invalid = r_err;

endmodule

// File: tb/tb_morse_serial_tx.sv
// Scoreboard bench for morse_serial_tx: stimulus queues expected mark/space/gap runs, a monitor measures key_out and busy.
module tb_morse_serial_tx;

    localparam int K_MARK  = 0;
    localparam int K_SPACE = 1;
    localparam int K_CGAP  = 2;

    typedef struct {
        int kind;
        int len;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       key_out;
    logic       busy;
    logic       err_invalid;
    logic [2:0] fifo_count;

    morse_serial_tx_if bus ();

    morse_serial_tx #(
        .UNIT_CYCLES    (4),
        .DASH_UNITS     (3),
        .CHAR_GAP_UNITS (3),
        .DEPTH          (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_if       (bus),
        .flush       (flush),
        .key_out     (key_out),
        .busy        (busy),
        .err_invalid (err_invalid),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    // Hand-derived Morse patterns (bit 4 first, 1 = dash) and busy lengths at default timing.
    logic [4:0] pat_tbl [10] = '{5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001,
                                 5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110};
    int busy_tbl [10] = '{88, 80, 72, 64, 56, 48, 56, 64, 72, 80};

    ev_t ev_q[$];
    int  busy_q[$];
    int  checks = 0;
    int  failures = 0;
    bit  mon_mute = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_char(input int d);
        ev_t e;
        for (int i = 0; i < 5; i++) begin
            e.kind = K_MARK;
            e.len  = pat_tbl[d][4-i] ? 12 : 4;
            ev_q.push_back(e);
            if (i < 4) begin
                e.kind = K_SPACE;
                e.len  = 4;
                ev_q.push_back(e);
            end
        end
        e.kind = K_CGAP;
        e.len  = 12;
        ev_q.push_back(e);
        busy_q.push_back(busy_tbl[d]);
    endtask

    task automatic send(input int d);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_digit = 4'(d);
        while (!acc && n < 2000) begin
            acc = bus.in_ready;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            check("send_timeout", 0, 1);
        end else begin
            $display("tb: digit %0d accepted at %0t", d, $time);
            if (d <= 9 && !mon_mute) expect_char(d);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(busy == 1'b0 && fifo_count == 3'd0 && ev_q.size() == 0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check("wait_idle_timeout", 0, 1);
    endtask

    task automatic wait_key();
        int n;
        n = 0;
        while (key_out != 1'b1 && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) check("wait_key_timeout", 0, 1);
    endtask

    task automatic mon_cmp(input int kind, input int len);
        ev_t e;
        checks++;
        if (ev_q.size() == 0) begin
            failures++;
            $display("FAIL run_unexpected: kind %0d len %0d with nothing expected at %0t", kind, len, $time);
        end else begin
            e = ev_q.pop_front();
            if (e.kind != kind || e.len != len) begin
                failures++;
                $display("FAIL run_shape: got kind %0d len %0d expected kind %0d len %0d at %0t",
                         kind, len, e.kind, e.len, $time);
            end
        end
    endtask

    task automatic busy_cmp(input int len);
        int exp;
        checks++;
        if (busy_q.size() == 0) begin
            failures++;
            $display("FAIL busy_unexpected: busy run %0d with nothing expected at %0t", len, $time);
        end else begin
            exp = busy_q.pop_front();
            if (len != exp) begin
                failures++;
                $display("FAIL busy_len: got %0d expected %0d at %0t", len, exp, $time);
            end else begin
                $display("tb: character done, busy %0d cycles at %0t", len, $time);
            end
        end
    endtask

    // Monitor: measures run lengths on the falling edge, away from the active edge.
    initial begin
        bit prev_key, prev_busy, low_active;
        int run_mark, run_low, run_busy;
        prev_key = 0; prev_busy = 0; low_active = 0;
        run_mark = 0; run_low = 0; run_busy = 0;
        forever begin
            @(negedge clk);
            if (!reset || mon_mute) begin
                low_active = 0;
                run_mark = 0;
                run_low = 0;
                run_busy = 0;
            end else begin
                if (key_out && !prev_key) begin
                    if (low_active) mon_cmp(K_SPACE, run_low);
                    low_active = 0;
                    run_mark = 0;
                end
                if (key_out) run_mark++;
                if (!key_out && prev_key) begin
                    mon_cmp(K_MARK, run_mark);
                    low_active = 1;
                    run_low = 0;
                end
                if (!key_out && busy && low_active) run_low++;
                if (busy && !prev_busy) run_busy = 0;
                if (busy) run_busy++;
                if (!busy && prev_busy) begin
                    if (low_active) mon_cmp(K_CGAP, run_low);
                    low_active = 0;
                    busy_cmp(run_busy);
                end
            end
            prev_key  = key_out;
            prev_busy = busy;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq[$];
        int last, idle_cnt, n;
        bit seen_pop, done;

        bus.in_valid = 1'b0;
        bus.in_digit = 4'd0;
        tick();
        tick();
        check("rst_key", key_out, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_invalid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", bus.in_ready, 1);
        reset = 1'b1;
        tick();

        // Digit 1 into an empty FIFO, then 5 and 0 queued during its character gap.
        send(1);
        check("t1_key_before", key_out, 0);
        check("t1_count", fifo_count, 1);
        tick();
        check("t1_key_rise", key_out, 1);
        check("t1_busy_rise", busy, 1);
        repeat (68) tick();
        send(5);
        check("t2_count_a", fifo_count, 1);
        send(0);
        check("t2_count_b", fifo_count, 2);
        last = 2;
        idle_cnt = 0;
        n = 0;
        while (seq.size() < 2 && n < 400) begin
            tick();
            n++;
            if (seq.size() == 1 && busy == 1'b0) idle_cnt++;
            if (fifo_count != 3'(last)) begin
                last = fifo_count;
                seq.push_back(last);
            end
        end
        check("t2_seq_len", seq.size(), 2);
        if (seq.size() == 2) begin
            check("t2_count_c", seq[0], 1);
            check("t2_count_d", seq[1], 0);
        end
        check("t2_idle_gap", idle_cnt, 1);
        wait_idle();

        // Fill the FIFO while a character is in flight, then hold a fifth digit.
        send(6);
        repeat (3) tick();
        send(2);
        send(3);
        send(4);
        send(8);
        check("t3_count_full", fifo_count, 4);
        check("t3_ready_full", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_digit = 4'd7;
        seen_pop = 1'b0;
        done = 1'b0;
        n = 0;
        while (!done && n < 2000) begin
            tick();
            n++;
            if (!seen_pop) begin
                if (fifo_count == 3'd3) begin
                    seen_pop = 1'b1;
                    check("t3_ready_after_pop", bus.in_ready, 1);
                end
            end else begin
                check("t3_fifth_accepted", fifo_count, 4);
                check("t3_ready_refull", bus.in_ready, 0);
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        if (!done) check("t3_timeout", 0, 1);
        else begin
            $display("tb: digit 7 accepted at %0t", $time);
            expect_char(7);
        end
        wait_idle();

        // Invalid code 12 is dropped and flagged for one cycle.
        check("t4_err_idle", err_invalid, 0);
        bus.in_valid = 1'b1;
        bus.in_digit = 4'd12;
        tick();
        bus.in_valid = 1'b0;
        check("t4_err_pulse", err_invalid, 1);
        check("t4_count", fifo_count, 0);
        check("t4_key", key_out, 0);
        tick();
        check("t4_err_clear", err_invalid, 0);
        check("t4_key_later", key_out, 0);
        check("t4_busy_later", busy, 0);
        send(9);
        wait_idle();

        // Flush in the middle of the first dash of 7 with two digits queued.
        mon_mute = 1'b1;
        send(7);
        send(1);
        send(2);
        wait_key();
        repeat (5) tick();
        check("t5_key_mid_dash", key_out, 1);
        check("t5_count_pre", fifo_count, 2);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_digit = 4'd5;
        tick();
        check("t5_key", key_out, 0);
        check("t5_busy", busy, 0);
        check("t5_count", fifo_count, 0);
        check("t5_ready", bus.in_ready, 1);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("t5_count_after", fifo_count, 0);
        check("t5_busy_after", busy, 0);
        mon_mute = 1'b0;
        send(3);
        wait_idle();

        // Asynchronous reset while a mark is on the key.
        mon_mute = 1'b1;
        send(2);
        wait_key();
        tick();
        tick();
        #3;
        check("t6_key_pre", key_out, 1);
        reset = 1'b0;
        #1;
        check("t6_key_async", key_out, 0);
        check("t6_busy", busy, 0);
        check("t6_err", err_invalid, 0);
        check("t6_count", fifo_count, 0);
        check("t6_ready", bus.in_ready, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        mon_mute = 1'b0;
        send(2);
        wait_idle();

        repeat (4) tick();
        check("end_events_left", ev_q.size(), 0);
        check("end_busy_left", busy_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
